// File: rtl/hive_reg_mbox.sv
// rtl/hive_reg_mbox.sv - rbus mailbox: RX FIFO popped via DATA, TX holding register, STATUS; irq_o under HIVE_MBOX_IRQ_EN
module hive_reg_mbox #(
  parameter int ALU_W       = 32,
  parameter int RBUS_ADDR_W = 8,
  parameter int ADDR_BASE   = 'h20,
  parameter int RX_DEPTH    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [RBUS_ADDR_W-1:0] rbus_addr_i,
  input  logic                   rbus_wr_i,
  input  logic                   rbus_rd_i,
  input  logic [ALU_W-1:0]       rbus_wr_data_i,
  output logic [ALU_W-1:0]       rbus_rd_data_o,
  input  logic [ALU_W-1:0]       rx_data_i,
  input  logic                   rx_vld_i,
  output logic [ALU_W-1:0]       tx_data_o,
  output logic                   tx_vld_o,
  input  logic                   tx_rdy_i
`ifdef HIVE_MBOX_IRQ_EN
  ,
  output logic                   irq_o
`endif
);

  localparam int                     PTR_W     = $clog2(RX_DEPTH);
  localparam logic [RBUS_ADDR_W-1:0] ADDR_DATA = RBUS_ADDR_W'(ADDR_BASE);
  localparam logic [RBUS_ADDR_W-1:0] ADDR_STAT = RBUS_ADDR_W'(ADDR_BASE + 1);
  localparam logic [PTR_W:0]         LVL_FULL  = (PTR_W + 1)'(RX_DEPTH);
  localparam logic [PTR_W:0]         LVL_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]       PTR_ONE   = PTR_W'(1);

  logic [ALU_W-1:0] mem [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level;
  logic             rx_ovf;
  logic             rx_unf;
  logic             tx_ovf;
  logic             tx_vld_q;
  logic [ALU_W-1:0] tx_data_q;
  logic [ALU_W-1:0] rd_data_q;
  logic [ALU_W-1:0] status;

  logic sel_data, sel_stat, rx_empty, rx_full;
  logic pop_req, pop_ok, push_ok, ovf_set, unf_set;
  logic tx_wr, tx_load, tx_ovf_set, w1c;

  // Decode and per-cycle event qualification; a pop on a full FIFO frees a slot for a same-cycle push
  always_comb begin
    sel_data   = (rbus_addr_i == ADDR_DATA);
    sel_stat   = (rbus_addr_i == ADDR_STAT);
    rx_empty   = (level == '0);
    rx_full    = (level == LVL_FULL);
    pop_req    = rbus_rd_i && sel_data;
    pop_ok     = pop_req && !rx_empty;
    unf_set    = pop_req && rx_empty;
    push_ok    = rx_vld_i && (!rx_full || pop_req);
    ovf_set    = rx_vld_i && rx_full && !pop_req;
    tx_wr      = rbus_wr_i && sel_data;
    tx_load    = tx_wr && (!tx_vld_q || tx_rdy_i);
    tx_ovf_set = tx_wr && !tx_load;
    w1c        = rbus_wr_i && sel_stat;
  end

  // STATUS word assembled from the state as it stands before this cycle's updates
  always_comb begin
    status       = '0;
    status[15:0] = 16'(level);
    status[16]   = rx_empty;
    status[17]   = rx_full;
    status[18]   = tx_vld_q;
    status[24]   = rx_ovf;
    status[25]   = rx_unf;
    status[26]   = tx_ovf;
  end

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= rx_data_i;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop_ok)      level <= level + LVL_ONE;
      else if (pop_ok && !push_ok) level <= level - LVL_ONE;
    end
  end

  // Sticky error flags: W1C on STATUS, a same-cycle set takes priority
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_ovf <= 1'b0;
      rx_unf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      rx_ovf <= ovf_set    || (rx_ovf && !(w1c && rbus_wr_data_i[24]));
      rx_unf <= unf_set    || (rx_unf && !(w1c && rbus_wr_data_i[25]));
      tx_ovf <= tx_ovf_set || (tx_ovf && !(w1c && rbus_wr_data_i[26]));
    end
  end

  // TX holding register; data only changes when a write is accepted
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
    end else if (tx_load) begin
      tx_data_q <= rbus_wr_data_i;
      tx_vld_q  <= 1'b1;
    end else if (tx_vld_q && tx_rdy_i) begin
      tx_vld_q  <= 1'b0;
    end
  end

  // Registered read data, zero unless a selected read happened last cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= '0;
      if (pop_ok)                      rd_data_q <= mem[rd_ptr];
      else if (rbus_rd_i && sel_stat) rd_data_q <= status;
    end
  end

  assign rbus_rd_data_o = rd_data_q;
  assign tx_data_o      = tx_data_q;
  assign tx_vld_o       = tx_vld_q;

`ifdef HIVE_MBOX_IRQ_EN
  logic irq_q;

  // Interrupt follows RX non-empty one cycle after the level register changes
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) irq_q <= 1'b0;
    else          irq_q <= !rx_empty;
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_hive_reg_mbox.sv
// tb/tb_hive_reg_mbox.sv - directed and random checks of hive_reg_mbox against a queue-based mailbox model
module tb_hive_reg_mbox;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rbus_addr = '0;
  logic        rbus_wr = 1'b0;
  logic        rbus_rd = 1'b0;
  logic [31:0] rbus_wr_data = '0;
  logic [31:0] rbus_rd_data;
  logic [31:0] rx_data = '0;
  logic        rx_vld = 1'b0;
  logic [31:0] tx_data;
  logic        tx_vld;
  logic        tx_rdy = 1'b0;
`ifdef HIVE_MBOX_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  hive_reg_mbox dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .rbus_addr_i    (rbus_addr),
    .rbus_wr_i      (rbus_wr),
    .rbus_rd_i      (rbus_rd),
    .rbus_wr_data_i (rbus_wr_data),
    .rbus_rd_data_o (rbus_rd_data),
    .rx_data_i      (rx_data),
    .rx_vld_i       (rx_vld),
    .tx_data_o      (tx_data),
    .tx_vld_o       (tx_vld),
    .tx_rdy_i       (tx_rdy)
`ifdef HIVE_MBOX_IRQ_EN
    ,
    .irq_o          (irq)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the mailbox
  logic [31:0] q[$];
  logic        m_txv;
  logic [31:0] m_txd;
  logic        m_ovf, m_unf, m_txovf;
  logic        m_irq;
  logic [31:0] last_rd;
  logic [31:0] first_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[15:0]  = 16'(q.size());
    s[16]    = (q.size() == 0);
    s[17]    = (q.size() == 16);
    s[18]    = m_txv;
    s[24]    = m_ovf;
    s[25]    = m_unf;
    s[26]    = m_txovf;
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    m_txv = 0; m_txd = '0; m_ovf = 0; m_unf = 0; m_txovf = 0; m_irq = 0;
  endtask

  // One clock cycle: drive inputs, advance the model, check outputs after the edge
  task automatic step(input logic [7:0] a, input logic wr, input logic rd, input logic [31:0] wd,
                      input logic rxv, input logic [31:0] rxd, input logic txr);
    logic [31:0] exp_rd;
    int          pre;
    logic        pop, ovf_s, unf_s, txo_s;
    rbus_addr = a; rbus_wr = wr; rbus_rd = rd; rbus_wr_data = wd;
    rx_vld = rxv; rx_data = rxd; tx_rdy = txr;
    exp_rd = '0; ovf_s = 0; unf_s = 0; txo_s = 0;
    pre = q.size();
    if (rd && a == 8'h21) exp_rd = model_status();
    pop = rd && (a == 8'h20);
    if (pop) begin
      if (pre == 0) unf_s = 1;
      else exp_rd = q.pop_front();
    end
    if (rxv) begin
      if (pre < 16 || pop) q.push_back(rxd);
      else ovf_s = 1;
    end
    if (wr && a == 8'h20) begin
      if (!m_txv || txr) begin m_txd = wd; m_txv = 1; end
      else txo_s = 1;
    end else if (m_txv && txr) begin
      m_txv = 0;
    end
    if (wr && a == 8'h21) begin
      if (wd[24]) m_ovf = 0;
      if (wd[25]) m_unf = 0;
      if (wd[26]) m_txovf = 0;
    end
    m_ovf = m_ovf | ovf_s;
    m_unf = m_unf | unf_s;
    m_txovf = m_txovf | txo_s;
    m_irq = (pre != 0);
    @(posedge clk);
    #1;
    last_rd = rbus_rd_data;
    chk("rd_data", rbus_rd_data, exp_rd);
    chk("tx_vld", {31'b0, tx_vld}, {31'b0, m_txv});
    chk("tx_data", tx_data, m_txd);
`ifdef HIVE_MBOX_IRQ_EN
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
    rbus_wr = 0; rbus_rd = 0; rx_vld = 0; tx_rdy = 0;
  endtask

  task automatic push(input logic [31:0] d);
    step(8'h00, 0, 0, '0, 1, d, 0);
  endtask

  task automatic rd_data_reg();
    step(8'h20, 0, 1, '0, 0, '0, 0);
  endtask

  task automatic rd_status();
    step(8'h21, 0, 1, '0, 0, '0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd"}, rbus_rd_data, 32'h0);
    chk({tag, "_txv"}, {31'b0, tx_vld}, 32'h0);
    chk({tag, "_txd"}, tx_data, 32'h0);
`ifdef HIVE_MBOX_IRQ_EN
    chk({tag, "_irq"}, {31'b0, irq}, 32'h0);
`endif
  endtask

  initial begin
    model_reset();
    last_rd = '0;
    first_word = '0;

    // Power-on reset
    #3;
    check_reset_outputs("por");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Basic FIFO order and empty status
    push(32'h11); push(32'h22); push(32'h33);
    rd_data_reg(); chk("pop1", last_rd, 32'h11);
    rd_data_reg(); chk("pop2", last_rd, 32'h22);
    rd_data_reg(); chk("pop3", last_rd, 32'h33);
    rd_status();   chk("status_empty", last_rd, 32'h0001_0000);

    // Overflow on the 17th push, then W1C of rx_ovf
    for (int i = 0; i < 17; i++) push($urandom);
    rd_status(); chk("status_ovf_full", last_rd, 32'h0102_0010);
    step(8'h21, 1, 0, 32'h0100_0000, 0, '0, 0);
    rd_status(); chk("status_w1c", last_rd, 32'h0002_0010);
    for (int i = 0; i < 16; i++) rd_data_reg();
    rd_status(); chk("status_drained", last_rd, 32'h0001_0000);

    // Underflow and same-cycle push/pop on an empty FIFO
    rd_data_reg(); chk("unf_data", last_rd, 32'h0);
    rd_status();   chk("unf_bit", {31'b0, last_rd[25]}, 32'h1);
    step(8'h20, 0, 1, '0, 1, 32'hAB, 0);
    chk("empty_pushpop_rd", last_rd, 32'h0);
    rd_status();   chk("empty_pushpop_lvl", {16'b0, last_rd[15:0]}, 32'h1);
    rd_data_reg(); chk("empty_pushpop_val", last_rd, 32'hAB);

    // Same-cycle push/pop on a full FIFO
    step(8'h21, 1, 0, 32'h0700_0000, 0, '0, 0);
    first_word = 32'h1000_0000;
    for (int i = 0; i < 16; i++) push(first_word + 32'(i));
    step(8'h20, 0, 1, '0, 1, 32'h55, 0);
    chk("full_pushpop_head", last_rd, first_word);
    rd_status(); chk("full_pushpop_status", last_rd, 32'h0002_0010);
    for (int i = 0; i < 16; i++) rd_data_reg();
    chk("full_pushpop_last", last_rd, 32'h55);

    // TX holding register
    step(8'h20, 1, 0, 32'hCAFE, 0, '0, 0);
    chk("tx_first", tx_data, 32'hCAFE);
    step(8'h20, 1, 0, 32'hBEEF, 0, '0, 0);
    chk("tx_drop", tx_data, 32'hCAFE);
    rd_status(); chk("tx_ovf_bit", {31'b0, last_rd[26]}, 32'h1);
    step(8'h20, 1, 0, 32'hF00D, 0, '0, 1);
    chk("tx_reload", tx_data, 32'hF00D);
    chk("tx_reload_vld", {31'b0, tx_vld}, 32'h1);
    step(8'h00, 0, 0, '0, 0, '0, 1);
    chk("tx_drained", {31'b0, tx_vld}, 32'h0);

    // Randomized traffic, alternating fill-heavy and drain-heavy phases
    for (int i = 0; i < 3000; i++) begin
      int          r;
      logic [7:0]  a;
      logic        rxv;
      r = $urandom_range(0, 9);
      if (r < 5)      a = 8'h20;
      else if (r < 8) a = 8'h21;
      else            a = 8'($urandom);
      rxv = ((i / 300) % 2 == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
      step(a, $urandom_range(0, 3) == 0, 1'($urandom), $urandom, rxv, $urandom, 1'($urandom));
    end

    // Reset mid-operation with queued RX words and a pending TX word
    step(8'h21, 1, 0, 32'h0700_0000, 0, '0, 0);
    for (int i = 0; i < 5; i++) push($urandom);
    step(8'h20, 1, 0, 32'h1234_5678, 0, '0, 0);
    rd_status();
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    rd_status(); chk("post_rst_status", last_rd, 32'h0001_0000);
    push(32'h77);
`ifdef HIVE_MBOX_IRQ_EN
    chk("irq_after_push", {31'b0, irq}, 32'h0);
`endif
    step(8'h00, 0, 0, '0, 0, '0, 0);
`ifdef HIVE_MBOX_IRQ_EN
    chk("irq_rise", {31'b0, irq}, 32'h1);
`endif
    rd_data_reg(); chk("post_rst_pop", last_rd, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
